// File: rtl/echo_pkg.sv
// Shared definitions for the echo enqueue arbiter slice.
//   ECHO_REC_WIDTH : record width (a, b, c0..c19, 32 bits each)
//   ECHO_NREQ      : number of requesters sharing the buffer
//   echo_req_id_t  : requester id carried in the owner queue
package echo_pkg;

   localparam int ECHO_REC_WIDTH = 704;
   localparam int ECHO_NREQ      = 2;

   typedef logic [0:0] echo_req_id_t;

   localparam echo_req_id_t ECHO_REQ0 = 1'b0;
   localparam echo_req_id_t ECHO_REQ1 = 1'b1;

endpackage : echo_pkg

// File: rtl/echo_owner_fifo.sv
// Owner-tag queue: remembers which requester enqueued each record held by
// the downstream buffer, in enqueue order.
// Ports:
//   CLK, nRST  : clock, synchronous active-low reset
//   push_i     : append tag_i (caller guarantees not full, unless popping)
//   tag_i      : requester id to append
//   pop_i      : drop the head tag (caller guarantees not empty)
//   head_o     : oldest tag
//   full_o     : DEPTH tags held
//   empty_o    : no tags held
module echo_owner_fifo
   import echo_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         push_i,
   input  echo_req_id_t tag_i,
   input  logic         pop_i,
   output echo_req_id_t head_o,
   output logic         full_o,
   output logic         empty_o
);

   // A depth of one still needs a one-bit pointer; it simply never moves.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   echo_req_id_t  mem_q [2**PW];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Tag storage carries no reset; only occupancy decides what is valid.
   always_ff @(posedge CLK) begin
      if (push_i) mem_q[wr_ptr_q] <= tag_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule : echo_owner_fifo

// File: rtl/echo_enq_arbiter.sv
// Shares one downstream record buffer between two echo requesters.
// Enqueue side is round-robin arbitrated with zero latency; the owner of
// each accepted record is queued so the buffer head is routed back to the
// requester that enqueued it.
// Ports:
//   CLK, nRST                         : clock, synchronous active-low reset
//   reqN_valid/reqN_data/reqN_ready   : enqueue handshake, requester N
//   rspN_valid/rspN_data/rspN_ready   : dequeue handshake, requester N
//   down_enq__ENA/_v/__RDY            : buffer enqueue method
//   down_first/down_first__RDY        : buffer head value
//   down_deq__ENA/__RDY               : buffer dequeue method
// Optional build macro ECHO_ARB_STATS_EN adds grant_count0/grant_count1,
// free-running 32-bit per-requester grant counters.
module echo_enq_arbiter
   import echo_pkg::*;
#(
   parameter int WIDTH       = ECHO_REC_WIDTH,
   parameter int OWNER_DEPTH = 1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             rsp0_valid,
   output logic [WIDTH-1:0] rsp0_data,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp1_data,
   input  logic             rsp1_ready,
   output logic             down_enq__ENA,
   output logic [WIDTH-1:0] down_enq_v,
   input  logic             down_enq__RDY,
   input  logic [WIDTH-1:0] down_first,
   input  logic             down_first__RDY,
   output logic             down_deq__ENA,
   input  logic             down_deq__RDY
`ifdef ECHO_ARB_STATS_EN
   ,
   output logic [31:0]      grant_count0,
   output logic [31:0]      grant_count1
`endif
);

   echo_req_id_t last_grant_q, last_grant_d;
   echo_req_id_t head_tag;
   logic         own_full, own_empty;
   logic         can_push, win1, grant0, grant1, any_grant;
   logic         head_ok;

   // Requester 1 wins when alone, or when both ask and requester 0 won last.
   assign can_push  = down_enq__RDY & ~own_full;
   assign win1      = req1_valid & (~req0_valid | (last_grant_q == ECHO_REQ0));
   assign grant1    = can_push & win1;
   assign grant0    = can_push & req0_valid & ~win1;
   assign any_grant = grant0 | grant1;

   assign req0_ready    = grant0;
   assign req1_ready    = grant1;
   assign down_enq__ENA = any_grant;
   assign down_enq_v    = grant0 ? req0_data :
                          grant1 ? req1_data : '0;

   always_comb begin
      last_grant_d = last_grant_q;
      if (grant0) last_grant_d = ECHO_REQ0;
      if (grant1) last_grant_d = ECHO_REQ1;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) last_grant_q <= ECHO_REQ1;
      else       last_grant_q <= last_grant_d;
   end

   // An empty owner queue with a valid buffer head is illegal; the head is
   // withheld from both requesters rather than routed to a stale tag.
   assign head_ok    = down_first__RDY & down_deq__RDY & ~own_empty;
   assign rsp0_valid = head_ok & (head_tag == ECHO_REQ0);
   assign rsp1_valid = head_ok & (head_tag == ECHO_REQ1);
   assign rsp0_data  = down_first;
   assign rsp1_data  = down_first;

   assign down_deq__ENA = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

   echo_owner_fifo #(
      .DEPTH (OWNER_DEPTH)
   ) u_owner_fifo (
      .CLK     (CLK),
      .nRST    (nRST),
      .push_i  (any_grant),
      .tag_i   (grant1 ? ECHO_REQ1 : ECHO_REQ0),
      .pop_i   (down_deq__ENA),
      .head_o  (head_tag),
      .full_o  (own_full),
      .empty_o (own_empty)
   );

`ifdef ECHO_ARB_STATS_EN
   logic [31:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (grant0) cnt0_d = cnt0_q + 32'd1;
      if (grant1) cnt1_d = cnt1_q + 32'd1;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign grant_count0 = cnt0_q;
   assign grant_count1 = cnt1_q;
`endif

endmodule : echo_enq_arbiter

// File: tb/tb_echo_enq_arbiter.sv
// Directed bench for echo_enq_arbiter: one instance with a single-entry
// owner queue and one with a four-entry owner queue.
module tb_echo_enq_arbiter;
   localparam int W = 704;

   logic CLK = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   // Instance with OWNER_DEPTH = 1
   logic         req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
   logic [W-1:0] req0_data = '0, req1_data = '0, down_first = '0;
   logic         down_enq__RDY = 0, down_first__RDY = 0, down_deq__RDY = 0;
   logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic         down_enq__ENA, down_deq__ENA;
   logic [W-1:0] rsp0_data, rsp1_data, down_enq_v;

   // Instance with OWNER_DEPTH = 4
   logic         b_req0_valid = 0, b_req1_valid = 0, b_rsp0_ready = 0, b_rsp1_ready = 0;
   logic [W-1:0] b_req0_data = '0, b_req1_data = '0, b_down_first = '0;
   logic         b_enq_rdy = 0, b_first_rdy = 0, b_deq_rdy = 0;
   logic         b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
   logic         b_enq_ena, b_deq_ena;
   logic [W-1:0] b_rsp0_data, b_rsp1_data, b_enq_v;

`ifdef ECHO_ARB_STATS_EN
   logic [31:0] gc0, gc1, b_gc0, b_gc1;
`endif

   echo_enq_arbiter #(.WIDTH(W), .OWNER_DEPTH(1)) dut (
      .CLK(CLK), .nRST(nRST),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
      .down_enq__ENA(down_enq__ENA), .down_enq_v(down_enq_v), .down_enq__RDY(down_enq__RDY),
      .down_first(down_first), .down_first__RDY(down_first__RDY),
      .down_deq__ENA(down_deq__ENA), .down_deq__RDY(down_deq__RDY)
`ifdef ECHO_ARB_STATS_EN
      , .grant_count0(gc0), .grant_count1(gc1)
`endif
   );

   echo_enq_arbiter #(.WIDTH(W), .OWNER_DEPTH(4)) dut4 (
      .CLK(CLK), .nRST(nRST),
      .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
      .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
      .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data), .rsp0_ready(b_rsp0_ready),
      .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data), .rsp1_ready(b_rsp1_ready),
      .down_enq__ENA(b_enq_ena), .down_enq_v(b_enq_v), .down_enq__RDY(b_enq_rdy),
      .down_first(b_down_first), .down_first__RDY(b_first_rdy),
      .down_deq__ENA(b_deq_ena), .down_deq__RDY(b_deq_rdy)
`ifdef ECHO_ARB_STATS_EN
      , .grant_count0(b_gc0), .grant_count1(b_gc1)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   logic [W-1:0] d0, d1, fh;
   logic [3:0]   b_tags;

   initial begin
      d0 = W'(8'hA5);
      d1 = {22{32'h1234_5678}};
      fh = {22{32'hCAFE_0001}};

      // Reset and release with idle inputs
      step(); step();
      nRST = 1'b1;
      #1;
      check("rst_req0_ready", W'(req0_ready), W'(0));
      check("rst_req1_ready", W'(req1_ready), W'(0));
      check("rst_enq_ena",    W'(down_enq__ENA), W'(0));
      check("rst_deq_ena",    W'(down_deq__ENA), W'(0));
      check("rst_rsp_valid",  W'({rsp1_valid, rsp0_valid}), W'(0));
      check("rst_enq_v",      down_enq_v, W'(0));

      // First grant to requester 0, same cycle
      req0_valid = 1; req0_data = d0; req1_data = d1; down_enq__RDY = 1;
      #1;
      check("g0_ready", W'(req0_ready), W'(1));
      check("g0_ena",   W'(down_enq__ENA), W'(1));
      check("g0_data",  down_enq_v, d0);
      step();

      // Owner queue now holds one tag: full, no grants to anyone
      req1_valid = 1;
      #1;
      check("full_ready", W'({req1_ready, req0_ready}), W'(0));
      check("full_ena",   W'(down_enq__ENA), W'(0));

      // Drain it: head belongs to requester 0
      req0_valid = 0; req1_valid = 0;
      down_first = fh; down_first__RDY = 1; down_deq__RDY = 1; rsp0_ready = 1; rsp1_ready = 1;
      #1;
      check("pop0_valid", W'({rsp1_valid, rsp0_valid}), W'(2'b01));
      check("pop0_data0", rsp0_data, fh);
      check("pop0_data1", rsp1_data, fh);
      check("pop0_deq",   W'(down_deq__ENA), W'(1));
      step();

      // Empty queue with a valid buffer head: nothing routed, no dequeue
      #1;
      check("empty_rsp", W'({rsp1_valid, rsp0_valid}), W'(0));
      check("empty_deq", W'(down_deq__ENA), W'(0));

      // Buffer not ready: no grant
      down_first__RDY = 0; down_enq__RDY = 0; req0_valid = 1;
      #1;
      check("nordy_ready", W'(req0_ready), W'(0));

      // Fresh reset, then alternation with both valid: 0,1,0,1
      nRST = 0; step(); nRST = 1;
      req0_valid = 1; req1_valid = 1; down_enq__RDY = 1;
      for (int k = 0; k < 4; k++) begin
         down_first__RDY = 0;
         #1;
         check($sformatf("alt%0d_ready", k), W'({req1_ready, req0_ready}),
               (k % 2 == 0) ? W'(2'b01) : W'(2'b10));
         check($sformatf("alt%0d_data", k), down_enq_v, (k % 2 == 0) ? d0 : d1);
         step();
         down_first__RDY = 1;
         #1;
         check($sformatf("alt%0d_hold", k), W'({req1_ready, req0_ready}), W'(0));
         check($sformatf("alt%0d_rsp", k), W'({rsp1_valid, rsp0_valid}),
               (k % 2 == 0) ? W'(2'b01) : W'(2'b10));
         check($sformatf("alt%0d_deq", k), W'(down_deq__ENA), W'(1));
         step();
      end

      // Head owned by requester 1; requester 0 ready must not dequeue it
      req0_valid = 0; req1_valid = 1; down_first__RDY = 0;
      #1;
      check("h1_grant", W'(req1_ready), W'(1));
      step();
      req1_valid = 0; down_first__RDY = 1; rsp0_ready = 1; rsp1_ready = 0;
      #1;
      check("h1_rsp",   W'({rsp1_valid, rsp0_valid}), W'(2'b10));
      check("h1_nodeq", W'(down_deq__ENA), W'(0));
      step();
      rsp1_ready = 1;
      #1;
      check("h1_deq", W'(down_deq__ENA), W'(1));
      step();
      down_first__RDY = 0; req0_valid = 1;
      #1;
      check("h1_empty_after", W'(req0_ready), W'(1));

      // Reset mid-stream: grant in flight is discarded
      req1_valid = 1; nRST = 0;
      step();
      nRST = 1;
      #1;
`ifdef ECHO_ARB_STATS_EN
      check("stat_rst0", W'(gc0), W'(0));
      check("stat_rst1", W'(gc1), W'(0));
`endif
      check("rst_mid_ready", W'({req1_ready, req0_ready}), W'(2'b01));
      step();
`ifdef ECHO_ARB_STATS_EN
      check("stat_cnt0", W'(gc0), W'(1));
      check("stat_cnt1", W'(gc1), W'(0));
`endif
      req0_valid = 0; req1_valid = 0;

      // Four-entry owner queue: tags 1,0,1 then push 0 with pop, push 1
      b_req0_data = d0; b_req1_data = d1; b_down_first = fh;
      b_enq_rdy = 1; b_deq_rdy = 1; b_rsp0_ready = 1; b_rsp1_ready = 1;
      b_tags = 4'b0101;
      for (int k = 0; k < 3; k++) begin
         b_req0_valid = ~b_tags[k]; b_req1_valid = b_tags[k];
         #1;
         check($sformatf("b_push%0d", k), W'({b_req1_ready, b_req0_ready}),
               b_tags[k] ? W'(2'b10) : W'(2'b01));
         step();
      end
      b_req0_valid = 1; b_req1_valid = 0; b_first_rdy = 1;
      #1;
      check("b_pp_grant", W'(b_req0_ready), W'(1));
      check("b_pp_rsp",   W'({b_rsp1_valid, b_rsp0_valid}), W'(2'b10));
      check("b_pp_deq",   W'(b_deq_ena), W'(1));
      step();
      b_req0_valid = 0; b_req1_valid = 1; b_first_rdy = 0;
      #1;
      check("b_push4", W'(b_req1_ready), W'(1));
      step();
      b_req0_valid = 1; b_req1_valid = 1;
      #1;
      check("b_full", W'({b_req1_ready, b_req0_ready}), W'(0));
      b_req0_valid = 0; b_req1_valid = 0; b_first_rdy = 1;
      // Remaining order: 0,1,0,1
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("b_pop%0d", k), W'({b_rsp1_valid, b_rsp0_valid}),
               (k % 2 == 0) ? W'(2'b01) : W'(2'b10));
         step();
      end
      #1;
      check("b_drained", W'({b_rsp1_valid, b_rsp0_valid, b_deq_ena}), W'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_echo_enq_arbiter
